tl_mem_responder: RTL

Synthesizable TileLink manager that answers built-in uncached acquires with grants, backed by internal data+tag storage. It is the responder end of the acquire/grant/finish interface that trace benches drive into the tag cache. It lets client-side traffic generators and tag-cache clients be tested without the NASTI memory path. It handles one transaction at a time.

---
 rtl/tl_mem_responder_if.sv | 57 +++++
 rtl/tl_mem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tl_mem_responder_if.sv
// Acquire/grant/finish channel bundle between a TileLink client and the memory responder.
interface tl_mem_responder_if #(
    parameter int ADDR_BLOCK_W = 26,
    parameter int DW           = 64,
    parameter int TW           = 4,
    parameter int CIS          = 7,
    parameter int MIS          = 2
);
    logic                    acq_valid;
    logic                    acq_ready;
    logic [ADDR_BLOCK_W-1:0] acq_addr_block;
    logic [CIS-1:0]          acq_client_xact_id;
    logic                    acq_client_id;
    logic [2:0]              acq_addr_beat;
    logic                    acq_is_builtin;
    logic [2:0]              acq_a_type;
    logic [12:0]             acq_union;
    logic [DW-1:0]           acq_data;
    logic [TW-1:0]           acq_tag;

    logic                    gnt_valid;
    logic                    gnt_ready;
    logic [2:0]              gnt_addr_beat;
    logic [CIS-1:0]          gnt_client_xact_id;
    logic                    gnt_client_id;
    logic [MIS-1:0]          gnt_manager_xact_id;
    logic                    gnt_is_builtin;
    logic [3:0]              gnt_g_type;
    logic [DW-1:0]           gnt_data;
    logic [TW-1:0]           gnt_tag;

    logic                    fin_valid;
    logic                    fin_ready;
    logic [MIS-1:0]          fin_manager_xact_id;

    modport master (
        output acq_valid, acq_addr_block, acq_client_xact_id, acq_client_id, acq_addr_beat,
               acq_is_builtin, acq_a_type, acq_union, acq_data, acq_tag,
        input  acq_ready,
        input  gnt_valid, gnt_addr_beat, gnt_client_xact_id, gnt_client_id,
               gnt_manager_xact_id, gnt_is_builtin, gnt_g_type, gnt_data, gnt_tag,
        output gnt_ready,
        output fin_valid, fin_manager_xact_id,
        input  fin_ready
    );

    modport slave (
        input  acq_valid, acq_addr_block, acq_client_xact_id, acq_client_id, acq_addr_beat,
               acq_is_builtin, acq_a_type, acq_union, acq_data, acq_tag,
        output acq_ready,
        output gnt_valid, gnt_addr_beat, gnt_client_xact_id, gnt_client_id,
               gnt_manager_xact_id, gnt_is_builtin, gnt_g_type, gnt_data, gnt_tag,
        input  gnt_ready,
        input  fin_valid, fin_manager_xact_id,
        output fin_ready
    );
endinterface

// File: rtl/tl_mem_responder.sv
// TileLink manager answering built-in uncached Get/GetBlock/Put/PutBlock from local
// data+tag storage, one transaction at a time, with a sticky protocol-error flag.
module tl_mem_responder #(
    parameter int ADDR_BLOCK_W = 26,
    parameter int DW           = 64,
    parameter int TW           = 4,
    parameter int CIS          = 7,
    parameter int MIS          = 2,
    parameter int BEATS        = 8,
    parameter int DEPTH        = 16,
    parameter int MGR_ID       = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    tl_mem_responder_if.slave   bus,
    output logic                err_o
);
    localparam int BW = $clog2(BEATS);
    localparam int IW = $clog2(DEPTH);
    localparam int NB = DW / 8;

    typedef enum logic [2:0] {IDLE, COLLECT, GNT_BEAT, GNT_BLK, GNT_ACK, WAIT_FIN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_BLOCK_W-1:0] blk_q, blk_d;
    logic [CIS-1:0]          xid_q, xid_d;
    logic                    cid_q, cid_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [BW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [DW-1:0]           mem_q [DEPTH*BEATS];
    logic [TW-1:0]           tag_q [DEPTH*BEATS];

    logic                    we, wtag_en, acq_rdy, gvld, fin_rdy, rd_vld, illegal;
    logic [NB-1:0]           wmask;
    logic [BW-1:0]           gbeat;
    logic [3:0]              g_type;
    logic [IW-1:0]           wblk;
    logic [IW+BW-1:0]        widx, ridx;
    logic                    unused_ok;

    assign illegal   = !bus.acq_is_builtin || (bus.acq_a_type > 3'd3);
    // The first beat of a transaction indexes with the incoming block; later beats use the latched one.
    assign wblk      = (state_q == IDLE) ? bus.acq_addr_block[IW-1:0] : blk_q[IW-1:0];
    assign widx      = {wblk, bus.acq_addr_beat[BW-1:0]};
    assign ridx      = {blk_q[IW-1:0], gbeat};
    assign rd_vld    = (state_q == GNT_BEAT) || (state_q == GNT_BLK);
    assign unused_ok = ^{bus.acq_union[12:NB+1], bus.acq_union[0]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            blk_q   <= '0;
            xid_q   <= '0;
            cid_q   <= 1'b0;
            beat_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            xid_q   <= xid_d;
            cid_q   <= cid_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we && !reset_i) begin
            for (int b = 0; b < NB; b++)
                if (wmask[b]) mem_q[widx][b*8 +: 8] <= bus.acq_data[b*8 +: 8];
            if (wtag_en) tag_q[widx] <= bus.acq_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        xid_d   = xid_q;
        cid_d   = cid_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we      = 1'b0;
        wtag_en = 1'b0;
        wmask   = '0;
        acq_rdy = 1'b0;
        gvld    = 1'b0;
        fin_rdy = 1'b0;
        g_type  = 4'd0;
        gbeat   = '0;
        if (bus.fin_valid && state_q != WAIT_FIN) err_d = 1'b1;
        case (state_q)
            IDLE: begin
                acq_rdy = 1'b1;
                if (bus.acq_valid) begin
                    blk_d  = bus.acq_addr_block;
                    xid_d  = bus.acq_client_xact_id;
                    cid_d  = bus.acq_client_id;
                    beat_d = bus.acq_addr_beat[BW-1:0];
                    cnt_d  = '0;
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = GNT_ACK;
                    end else begin
                        case (bus.acq_a_type[1:0])
                            2'd0: state_d = GNT_BEAT;
                            2'd1: state_d = GNT_BLK;
                            2'd2: begin
                                we      = 1'b1;
                                wmask   = bus.acq_union[NB:1];
                                wtag_en = |bus.acq_union[NB:1];
                                state_d = GNT_ACK;
                            end
                            default: begin
                                we      = 1'b1;
                                wmask   = '1;
                                wtag_en = 1'b1;
                                cnt_d   = BW'(1);
                                state_d = COLLECT;
                            end
                        endcase
                    end
                end
            end
            COLLECT: begin
                acq_rdy = 1'b1;
                if (bus.acq_valid) begin
                    we      = 1'b1;
                    wmask   = '1;
                    wtag_en = 1'b1;
                    if (bus.acq_addr_block != blk_q || bus.acq_client_xact_id != xid_q) err_d = 1'b1;
                    cnt_d = cnt_q + BW'(1);
                    if (cnt_q == BW'(BEATS-1)) state_d = GNT_ACK;
                end
            end
            GNT_BEAT: begin
                gvld   = 1'b1;
                g_type = 4'd4;
                gbeat  = beat_q;
                if (bus.gnt_ready) state_d = WAIT_FIN;
            end
            GNT_BLK: begin
                gvld   = 1'b1;
                g_type = 4'd5;
                gbeat  = cnt_q;
                if (bus.gnt_ready) begin
                    cnt_d = cnt_q + BW'(1);
                    if (cnt_q == BW'(BEATS-1)) state_d = WAIT_FIN;
                end
            end
            GNT_ACK: begin
                gvld   = 1'b1;
                g_type = 4'd3;
                if (bus.gnt_ready) state_d = WAIT_FIN;
            end
            WAIT_FIN: begin
                fin_rdy = 1'b1;
                if (bus.fin_valid) begin
                    if (bus.fin_manager_xact_id != MIS'(MGR_ID)) err_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.acq_ready           = acq_rdy;
    assign bus.fin_ready           = fin_rdy;
    assign bus.gnt_valid           = gvld;
    assign bus.gnt_g_type          = g_type;
    assign bus.gnt_addr_beat       = 3'(gbeat);
    assign bus.gnt_is_builtin      = gvld;
    assign bus.gnt_client_xact_id  = gvld ? xid_q : '0;
    assign bus.gnt_client_id       = gvld & cid_q;
    assign bus.gnt_manager_xact_id = gvld ? MIS'(MGR_ID) : '0;
    assign bus.gnt_data            = rd_vld ? mem_q[ridx] : '0;
    assign bus.gnt_tag             = rd_vld ? tag_q[ridx] : '0;
    assign err_o                   = err_q;
endmodule
